// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes and field helpers.
package cp0_pkg;

    localparam int unsigned IRQ_W  = 6;
    localparam int unsigned IM_LSB = 10;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    // Restart PC for a faulting instruction: delay-slot instructions restart at the branch.
    function automatic logic [29:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] t;
        t = bd ? (pc - 32'd4) : pc;
        return t[31:2];
    endfunction

endpackage

// File: rtl/cp0_irq_arb.sv
// Interrupt vs synchronous-exception arbitration; interrupts win and record ExcCode 0.
module cp0_irq_arb
    import cp0_pkg::*;
#(
    parameter int unsigned W = IRQ_W
) (
    input  logic [W-1:0] hwint,
    input  logic [W-1:0] im,
    input  logic         ie,
    input  logic         exl,
    input  logic [4:0]   exccode,
    output logic         req_c,
    output logic [4:0]   code_c
);

    logic int_take;
    logic exc_take;

    always_comb begin
        int_take = (|(hwint & im)) & ie & ~exl;
        exc_take = (exccode != 5'd0) & ~exl;
        req_c    = int_take | exc_take;
        code_c   = int_take ? EXC_INT : exccode;
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId storage, handler entry request and eret target.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h4D42_0007,
    parameter int unsigned HWINT_W    = IRQ_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [4:0]         cp0_addr,
    input  logic               cp0_we,
    input  logic [31:0]        cp0_wdata,
    input  logic [31:0]        pc_m,
    input  logic               bd_m,
    input  logic [4:0]         exccode_m,
    input  logic               eret_m,
    input  logic [HWINT_W-1:0] hwint,
    output logic [31:0]        cp0_rdata,
    output logic [31:0]        epc_out,
    output logic               exc_req
);

    logic [HWINT_W-1:0] sr_im;
    logic               sr_exl;
    logic               sr_ie;
    logic               cause_bd;
    logic [HWINT_W-1:0] cause_ip;
    logic [4:0]         cause_exc;
    logic [29:0]        epc;
    logic [4:0]         exc_code;
    logic [31:0]        sr_word;
    logic [31:0]        cause_word;

    cp0_irq_arb #(.W(HWINT_W)) u_arb (
        .hwint   (hwint),
        .im      (sr_im),
        .ie      (sr_ie),
        .exl     (sr_exl),
        .exccode (exccode_m),
        .req_c   (exc_req),
        .code_c  (exc_code)
    );

    // Register-update priority: reset, handler entry, eret, mtc0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hwint;
            if (exc_req) begin
                sr_exl    <= 1'b1;
                cause_exc <= exc_code;
                cause_bd  <= bd_m;
                epc       <= epc_of(pc_m, bd_m);
            end else if (eret_m) begin
                sr_exl <= 1'b0;
            end else if (cp0_we) begin
                case (cp0_addr)
                    CP0_SR: begin
                        sr_im  <= cp0_wdata[IM_LSB +: HWINT_W];
                        sr_exl <= cp0_wdata[1];
                        sr_ie  <= cp0_wdata[0];
                    end
                    CP0_EPC: epc <= cp0_wdata[31:2];
                    default: ;
                endcase
            end
        end
    end

    // mfc0 read mux; reads see the pre-write register value.
    always_comb begin
        sr_word                     = '0;
        sr_word[IM_LSB +: HWINT_W]  = sr_im;
        sr_word[1]                  = sr_exl;
        sr_word[0]                  = sr_ie;
        cause_word                  = '0;
        cause_word[31]              = cause_bd;
        cause_word[IM_LSB +: HWINT_W] = cause_ip;
        cause_word[6:2]             = cause_exc;
        epc_out                     = {epc, 2'b00};
        case (cp0_addr)
            CP0_SR:    cp0_rdata = sr_word;
            CP0_CAUSE: cp0_rdata = cause_word;
            CP0_EPC:   cp0_rdata = epc_out;
            CP0_PRID:  cp0_rdata = PRID_VALUE;
            default:   cp0_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, interrupt/exception entry, eret, mtc0/mfc0 edge cases.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exccode_m;
    logic        eret_m;
    logic [5:0]  hwint;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        exc_req;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cp0_addr  (cp0_addr),
        .cp0_we    (cp0_we),
        .cp0_wdata (cp0_wdata),
        .pc_m      (pc_m),
        .bd_m      (bd_m),
        .exccode_m (exccode_m),
        .eret_m    (eret_m),
        .hwint     (hwint),
        .cp0_rdata (cp0_rdata),
        .epc_out   (epc_out),
        .exc_req   (exc_req)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
        cyc();
        cp0_we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cp0_addr = 5'd12; cp0_we = 1'b1; cp0_wdata = 32'hFFFF_FFFF;
        pc_m = 32'h0; bd_m = 1'b0; exccode_m = 5'd0; eret_m = 1'b0; hwint = 6'h3F;

        // Reset held with write and interrupts active
        cyc(); cyc();
        cp0_we = 1'b0;
        chk_reg("rst_sr", 5'd12, 32'h0);
        chk_reg("rst_cause", 5'd13, 32'h0);
        chk_reg("rst_epc", 5'd14, 32'h0);
        chk_reg("rst_prid", 5'd15, 32'h4D42_0007);
        check("rst_req", 32'(exc_req), 32'h0);
        check("rst_epc_out", epc_out, 32'h0);
        reset_n = 1'b1; hwint = 6'h0;
        cyc();

        // Interrupt entry
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
        #1 check("sr_nobypass", cp0_rdata, 32'h0);
        cyc(); cp0_we = 1'b0;
        chk_reg("sr_written", 5'd12, 32'h0000_FC01);
        hwint = 6'b000100; pc_m = 32'h0000_3010; bd_m = 1'b0;
        #1 check("int_req", 32'(exc_req), 32'h1);
        cyc();
        chk_reg("int_epc", 5'd14, 32'h0000_3010);
        chk_reg("int_cause", 5'd13, 32'h0000_1000);
        chk_reg("int_sr", 5'd12, 32'h0000_FC03);
        check("int_req_off", 32'(exc_req), 32'h0);
        check("int_epc_out", epc_out, 32'h0000_3010);

        // Handler holds off interrupts; eret with pending interrupt re-requests
        cyc();
        check("hdl_no_nest", 32'(exc_req), 32'h0);
        eret_m = 1'b1;
        #1 check("eret_cycle_req", 32'(exc_req), 32'h0);
        cyc(); eret_m = 1'b0;
        chk_reg("eret_sr", 5'd12, 32'h0000_FC01);
        check("eret_req_rise", 32'(exc_req), 32'h1);
        check("eret_epc_keep", epc_out, 32'h0000_3010);
        hwint = 6'h0;
        #1 check("req_drop", 32'(exc_req), 32'h0);

        // Synchronous exception in delay slot with IE=0
        mtc0(5'd12, 32'h0000_FC00);
        hwint = 6'b000011; exccode_m = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3024;
        #1 check("exc_req", 32'(exc_req), 32'h1);
        cyc();
        exccode_m = 5'd0; bd_m = 1'b0; hwint = 6'h0;
        chk_reg("exc_epc", 5'd14, 32'h0000_3020);
        chk_reg("exc_cause", 5'd13, 32'h8000_0C30);
        chk_reg("exc_sr", 5'd12, 32'h0000_FC02);
        mtc0(5'd12, 32'h0000_FC00);
        chk_reg("mtc0_exl_clr", 5'd12, 32'h0000_FC00);

        // Interrupt beats exception; concurrent mtc0 EPC dropped
        mtc0(5'd12, 32'h0000_FC01);
        hwint = 6'b100000; exccode_m = 5'd4; pc_m = 32'h0000_5000;
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
        #1 check("both_req", 32'(exc_req), 32'h1);
        cyc();
        cp0_we = 1'b0; exccode_m = 5'd0; hwint = 6'h0;
        chk_reg("both_epc", 5'd14, 32'h0000_5000);
        chk_reg("both_cause", 5'd13, 32'h0000_8000);
        eret_m = 1'b1; cyc(); eret_m = 1'b0;
        chk_reg("both_eret_sr", 5'd12, 32'h0000_FC01);

        // mtc0 edge cases
        mtc0(5'd14, 32'h0000_3007);
        chk_reg("epc_lowbits", 5'd14, 32'h0000_3004);
        check("epc_out_low", epc_out, 32'h0000_3004);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk_reg("cause_ro", 5'd13, 32'h0000_0000);
        mtc0(5'd9, 32'hFFFF_FFFF);
        chk_reg("addr9_zero", 5'd9, 32'h0);
        chk_reg("addr9_sr", 5'd12, 32'h0000_FC01);
        chk_reg("addr9_epc", 5'd14, 32'h0000_3004);
        mtc0(5'd15, 32'h0);
        chk_reg("prid_ro", 5'd15, 32'h4D42_0007);
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0400;
        #1 check("sr_old_in_wr", cp0_rdata, 32'h0000_FC01);
        cyc(); cp0_we = 1'b0;
        chk_reg("sr_new", 5'd12, 32'h0000_0400);

        // Delay-slot EPC wrap at PC 0; eret beats concurrent mtc0
        exccode_m = 5'd10; bd_m = 1'b1; pc_m = 32'h0;
        cyc();
        exccode_m = 5'd0; bd_m = 1'b0;
        chk_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        chk_reg("wrap_cause", 5'd13, 32'h8000_0028);
        eret_m = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0001;
        cyc();
        eret_m = 1'b0; cp0_we = 1'b0;
        chk_reg("eret_over_mtc0", 5'd12, 32'h0000_0400);

        // Reset mid-handler with interrupt pending
        mtc0(5'd12, 32'h0000_FC01);
        exccode_m = 5'd5; pc_m = 32'h0000_6000;
        cyc();
        exccode_m = 5'd0; hwint = 6'h3F;
        chk_reg("pre_rst_sr", 5'd12, 32'h0000_FC03);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk_reg("midrst_sr", 5'd12, 32'h0);
        chk_reg("midrst_epc", 5'd14, 32'h0);
        check("midrst_req", 32'(exc_req), 32'h0);
        cyc();
        check("midrst_req_hold", 32'(exc_req), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
